pipe_ctrl: RTL

Pipeline controller for the five-stage MIPS core. It merges stall requests from ID, EX and MEM into the six-bit `stall` vector consumed by every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB). It turns MEM-stage exception codes into a single-cycle `flush` plus a redirect PC. It also runs a memory-wait watchdog and a free-running stall-cycle counter for performance monitoring.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl_mem_watchdog.sv | 25 ++
 rtl/pipe_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
// Holds stall polarity, exception codes, FSM state encodings and the stall-merge helper.
package pipe_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int EXC_CODE_WIDTH = 5;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = 5'h00;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_OV   = 5'h0c;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ERET = 5'h0e;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_RUN     = 2'b00,
        PC_FLUSH   = 2'b01,
        PC_TOFLUSH = 2'b10
    } pc_state_e;

    // A later stage stalling must also freeze every stage in front of it.
    function automatic logic [5:0] merge_stall(input logic id, input logic ex, input logic mem);
        logic [5:0] s;
        s = {6{NOSTOP}};
        if (mem)
            s = {NOSTOP, {5{STOP}}};
        else if (ex)
            s = {NOSTOP, NOSTOP, {4{STOP}}};
        else if (id)
            s = {NOSTOP, NOSTOP, NOSTOP, {3{STOP}}};
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of stall requests, exception inputs and control outputs of the pipeline controller.
// The master modport is the controller itself; the slave modport is the pipeline side.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                      stallreq_id;
    logic                      stallreq_ex;
    logic                      stallreq_mem;
    logic [EXC_CODE_WIDTH-1:0] exc_code_i;
    logic [31:0]               cp0_epc_i;
    logic [5:0]                stall;
    logic                      flush;
    logic [31:0]               new_pc;
    logic                      mem_cancel;
    logic                      bus_timeout;
    logic [31:0]               stall_cycles;

    modport master (
        input  stallreq_id, stallreq_ex, stallreq_mem, exc_code_i, cp0_epc_i,
        output stall, flush, new_pc, mem_cancel, bus_timeout, stall_cycles
    );

    modport slave (
        output stallreq_id, stallreq_ex, stallreq_mem, exc_code_i, cp0_epc_i,
        input  stall, flush, new_pc, mem_cancel, bus_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_mem_watchdog.sv
// Memory-wait watchdog: counts consecutive enabled cycles and flags the last one
// before the limit so the controller can schedule a timeout flush.
module pipe_ctrl_mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    output logic        expire,
    output logic [15:0] cnt
);

    localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst || clr)
            cnt <= 16'd0;
        else if (en)
            cnt <= cnt + 16'd1;
    end

    assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, converts MEM exceptions and
// memory-bus timeouts into a one-cycle flush with redirect PC, and counts stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.master   bus
);

    pc_state_e   state;
    pc_state_e   next_state;
    logic        exc_hit;
    logic        wd_en;
    logic        wd_expire;
    logic [15:0] wd_cnt;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        mem_cancel_o;
    logic [31:0] stall_cnt;

    assign exc_hit = (bus.exc_code_i != EC_NONE);
    assign wd_en   = rst && (state == PC_RUN) && bus.stallreq_mem && !exc_hit;

    pipe_ctrl_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .clr    (!wd_en),
        .expire (wd_expire),
        .cnt    (wd_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state <= PC_RUN;
        else
            state <= next_state;
    end

    // Exception beats watchdog expiry, which beats ordinary stall requests.
    always_comb begin
        next_state   = state;
        stall_o      = {6{NOSTOP}};
        flush_o      = 1'b0;
        new_pc_o     = ZeroWord;
        mem_cancel_o = 1'b0;
        if (rst) begin
            case (state)
                PC_RUN: begin
                    if (exc_hit) begin
                        flush_o      = 1'b1;
                        mem_cancel_o = bus.stallreq_mem;
                        new_pc_o     = (bus.exc_code_i == EC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
                        next_state   = PC_FLUSH;
                    end else if (wd_expire) begin
                        next_state   = PC_TOFLUSH;
                    end else begin
                        stall_o      = merge_stall(bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
                    end
                end
                PC_TOFLUSH: begin
                    flush_o      = 1'b1;
                    mem_cancel_o = 1'b1;
                    new_pc_o     = EXC_VECTOR;
                    next_state   = PC_FLUSH;
                end
                PC_FLUSH:  next_state = PC_RUN;
                default:   next_state = PC_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= 32'd0;
        else if (stall_o != 6'd0)
            stall_cnt <= stall_cnt + 32'd1;
    end

    // Both entries into FLUSH clear the watchdog on the way in.
    assert property (@(posedge clk) disable iff (!rst) (state == PC_FLUSH) |-> (wd_cnt == 16'd0));

    assign bus.stall        = stall_o;
    assign bus.flush        = flush_o;
    assign bus.new_pc       = new_pc_o;
    assign bus.mem_cancel   = mem_cancel_o;
    assign bus.bus_timeout  = rst && (state == PC_TOFLUSH);
    assign bus.stall_cycles = stall_cnt;

endmodule
